debounce_bank: RTL and testbench

//  Multi-channel switch/button debouncer with edge and long-press detection. Synchronises
//  NUM_CH raw inputs, filters each on a shared prescaled time base and emits the debounced

---
 rtl/debounce_bank_pkg.sv | 20 ++
 rtl/debounce_bank_chan.sv | 98 +++++++++
 rtl/debounce_bank.sv | 66 ++++++
 tb/tb_debounce_bank.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/debounce_bank_pkg.sv
// Shared timing defaults and helper types for the front-panel debounce bank.
package debounce_bank_pkg;

  localparam int unsigned DB_TICK_1MS_25MHZ = 25000;
  localparam int unsigned DB_DEBOUNCE_MS    = 10;
  localparam int unsigned DB_HOLD_MS        = 1000;

  // Per-channel pulses computed combinationally and registered in one place.
  typedef struct packed {
    logic rise;
    logic fall;
    logic hold;
  } chan_evt_t;

  // Counter width able to hold 0..n, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n == 0) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/debounce_bank_chan.sv
// One debounce channel: 2-FF synchroniser, tick-based debounce filter,
// long-press hold counter and registered edge/hold pulses.
module debounce_chan
  import debounce_bank_pkg::*;
#(
  parameter int unsigned DEBOUNCE_TICKS = DB_DEBOUNCE_MS,
  parameter int unsigned HOLD_TICKS     = DB_HOLD_MS,
  parameter logic        INIT_LEVEL     = 1'b0
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_Tick,
  input  logic i_Switch,
  output logic o_State,
  output logic o_Rise,
  output logic o_Fall,
  output logic o_Hold,
  output logic o_Edge_next
);

  localparam int unsigned     DW      = cnt_width(DEBOUNCE_TICKS);
  localparam logic [DW-1:0]   DB_LAST = DW'(DEBOUNCE_TICKS - 1);

  logic [1:0]    sync;
  logic [DW-1:0] db_cnt;
  logic          state;
  logic          accept;
  logic          hold_hit;
  chan_evt_t     evt_next;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) sync <= {2{INIT_LEVEL}};
    else       sync <= {sync[0], i_Switch};
  end

  assign accept = (sync[1] != state) && i_Tick && (db_cnt >= DB_LAST);

  // Any clock where the input agrees with the accepted level restarts the filter.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      db_cnt <= '0;
      state  <= INIT_LEVEL;
    end else if (sync[1] == state) begin
      db_cnt <= '0;
    end else if (i_Tick) begin
      if (accept) begin
        state  <= sync[1];
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  generate
    if (HOLD_TICKS > 0) begin : g_hold
      localparam int unsigned   HW        = cnt_width(HOLD_TICKS);
      localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);
      localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_TICKS);
      logic [HW-1:0] hold_cnt;

      // Saturates at HOLD_MAX so the pulse fires once per press.
      always_ff @(posedge i_Clk) begin
        if (i_Rst || !state)                      hold_cnt <= '0;
        else if (i_Tick && (hold_cnt != HOLD_MAX)) hold_cnt <= hold_cnt + 1'b1;
      end

      assign hold_hit = state && i_Tick && (hold_cnt == HOLD_LAST);
    end else begin : g_no_hold
      assign hold_hit = 1'b0;
    end
  endgenerate

  always_comb begin
    evt_next = '0;
    if (accept) begin
      evt_next.rise = sync[1];
      evt_next.fall = !sync[1];
    end
    evt_next.hold = hold_hit;
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      o_Rise <= 1'b0;
      o_Fall <= 1'b0;
      o_Hold <= 1'b0;
    end else begin
      o_Rise <= evt_next.rise;
      o_Fall <= evt_next.fall;
      o_Hold <= evt_next.hold;
    end
  end

  assign o_State     = state;
  assign o_Edge_next = accept;

endmodule

// File: rtl/debounce_bank.sv
// Multi-channel switch debouncer: shared prescaled tick, one debounce_chan per
// input and a registered change strobe across all channels.
module debounce_bank
  import debounce_bank_pkg::*;
#(
  parameter int unsigned       NUM_CH         = 4,
  parameter int unsigned       TICK_DIV       = DB_TICK_1MS_25MHZ,
  parameter int unsigned       DEBOUNCE_TICKS = DB_DEBOUNCE_MS,
  parameter int unsigned       HOLD_TICKS     = DB_HOLD_MS,
  parameter logic [NUM_CH-1:0] INIT_LEVEL     = '0
) (
  input  logic              i_Clk,
  input  logic              i_Rst,
  input  logic [NUM_CH-1:0] i_Switch,
  output logic [NUM_CH-1:0] o_State,
  output logic [NUM_CH-1:0] o_Rise,
  output logic [NUM_CH-1:0] o_Fall,
  output logic [NUM_CH-1:0] o_Hold,
  output logic              o_Any
);

  logic              tick;
  logic [NUM_CH-1:0] edge_next;

  generate
    if (TICK_DIV > 1) begin : g_prescale
      localparam int unsigned   PW       = $clog2(TICK_DIV);
      localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
      logic [PW-1:0] pre_cnt;

      always_ff @(posedge i_Clk) begin
        if (i_Rst || tick) pre_cnt <= '0;
        else               pre_cnt <= pre_cnt + 1'b1;
      end

      assign tick = (pre_cnt == PRE_LAST);
    end else begin : g_no_prescale
      assign tick = 1'b1;
    end
  endgenerate

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    debounce_chan #(
      .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
      .HOLD_TICKS     (HOLD_TICKS),
      .INIT_LEVEL     (INIT_LEVEL[g])
    ) u_chan (
      .i_Clk       (i_Clk),
      .i_Rst       (i_Rst),
      .i_Tick      (tick),
      .i_Switch    (i_Switch[g]),
      .o_State     (o_State[g]),
      .o_Rise      (o_Rise[g]),
      .o_Fall      (o_Fall[g]),
      .o_Hold      (o_Hold[g]),
      .o_Edge_next (edge_next[g])
    );
  end

  // Registered from the pre-edge accept terms so it lines up with o_Rise/o_Fall.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) o_Any <= 1'b0;
    else       o_Any <= |edge_next;
  end

endmodule

// File: tb/tb_debounce_bank.sv
// Directed bench: cycle-exact vector table for reset/rise/hold/fall, then
// hand-written sequences for bounce, glitch, re-press, reset and TICK_DIV=1.
module tb_debounce_bank;

  localparam int NV = 52;

  typedef struct {
    logic       rst;
    logic [3:0] sw;
    logic [3:0] st;
    logic [3:0] ri;
    logic [3:0] fa;
    logic [3:0] ho;
    logic       any;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_a = 1'b1, rst_b = 1'b1;
  logic [3:0] sw_a = 4'hF, sw_b = 4'b1000;
  logic [3:0] st_a, ri_a, fa_a, ho_a, st_b, ri_b, fa_b, ho_b;
  logic       any_a, any_b;

  always #5 clk = ~clk;

  debounce_bank #(
    .NUM_CH(4), .TICK_DIV(4), .DEBOUNCE_TICKS(3), .HOLD_TICKS(5), .INIT_LEVEL(4'b0000)
  ) dut_a (
    .i_Clk(clk), .i_Rst(rst_a), .i_Switch(sw_a), .o_State(st_a),
    .o_Rise(ri_a), .o_Fall(fa_a), .o_Hold(ho_a), .o_Any(any_a)
  );

  debounce_bank #(
    .NUM_CH(4), .TICK_DIV(1), .DEBOUNCE_TICKS(3), .HOLD_TICKS(5), .INIT_LEVEL(4'b1000)
  ) dut_b (
    .i_Clk(clk), .i_Rst(rst_b), .i_Switch(sw_b), .o_State(st_b),
    .o_Rise(ri_b), .o_Fall(fa_b), .o_Hold(ho_b), .o_Any(any_b)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rise_n[4], fall_n[4], hold_n[4], rise_at[4], hold_at[4], rise_b_n[4];
  int any_n = 0, any_bad = 0, both_n = 0;
  vec_t tbl[NV];

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor, sampled 1 time unit after each active edge.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 4; i++) begin
      if (ri_a[i] === 1'b1) begin rise_n[i]++; rise_at[i] = cyc; end
      if (fa_a[i] === 1'b1) fall_n[i]++;
      if (ho_a[i] === 1'b1) begin hold_n[i]++; hold_at[i] = cyc; end
      if (ri_a[i] === 1'b1 && fa_a[i] === 1'b1) both_n++;
      if (ri_b[i] === 1'b1) rise_b_n[i]++;
    end
    if (any_a === 1'b1) any_n++;
    if (!rst_a && (any_a !== |(ri_a | fa_a))) any_bad++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    for (int i = 0; i < 4; i++) begin
      rise_n[i] = 0; fall_n[i] = 0; hold_n[i] = 0; rise_b_n[i] = 0;
    end
    any_n = 0;
  endtask

  task automatic wait_cnt(input int which, input int ch, input int budget);
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (which == 0 && rise_n[ch] > 0) return;
      if (which == 1 && fall_n[ch] > 0) return;
      if (which == 2 && hold_n[ch] > 0) return;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, lat;

    // Hand-derived for TICK_DIV=4: ticks act on edges k=6,10,14,...;
    // accept at k=14 (rise), hold after 5 more ticks at k=34, fall at k=50.
    for (int k = 0; k < NV; k++) begin
      tbl[k].rst = (k < 3);
      tbl[k].sw  = (k < 37) ? 4'hF : 4'h0;
      tbl[k].st  = (k >= 14 && k < 50) ? 4'hF : 4'h0;
      tbl[k].ri  = (k == 14) ? 4'hF : 4'h0;
      tbl[k].fa  = (k == 50) ? 4'hF : 4'h0;
      tbl[k].ho  = (k == 34) ? 4'hF : 4'h0;
      tbl[k].any = (k == 14 || k == 50);
    end

    for (int k = 0; k < NV; k++) begin
      @(negedge clk);
      rst_a = tbl[k].rst;
      sw_a  = tbl[k].sw;
      @(posedge clk); #2;
      check($sformatf("vec%0d", k), {15'd0, st_a, ri_a, fa_a, ho_a, any_a},
            {15'd0, tbl[k].st, tbl[k].ri, tbl[k].fa, tbl[k].ho, tbl[k].any});
    end

    // Bounce on ch0: toggling every 3 clocks never survives three ticks.
    @(negedge clk);
    clear_mon();
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (n % 3 == 0) sw_a[0] = ~sw_a[0];
    end
    check("bounce_no_rise", rise_n[0], 0);
    check("bounce_no_fall", fall_n[0], 0);
    @(negedge clk);
    sw_a[0] = 1'b1;
    t0 = cyc;
    wait_cnt(0, 0, 20);
    check("bounce_rise_once", rise_n[0], 1);
    lat = rise_at[0] - t0;
    check("bounce_latency_in_10_14", (lat >= 10 && lat <= 14), 1);
    sw_a[0] = 1'b0;
    wait_cnt(1, 0, 20);
    check("bounce_fall_once", fall_n[0], 1);
    check("bounce_no_hold", hold_n[0], 0);

    // Short glitch on ch1: 8 clocks high spans at most two ticks.
    @(negedge clk);
    clear_mon();
    sw_a[1] = 1'b1;
    repeat (8) @(negedge clk);
    sw_a[1] = 1'b0;
    repeat (20) @(negedge clk);
    check("glitch_state", st_a[1], 0);
    check("glitch_no_rise", rise_n[1], 0);
    check("glitch_no_fall", fall_n[1], 0);
    check("glitch_no_any", any_n, 0);

    // Long press on ch2, twice: hold fires once per press, 20 clocks after rise.
    for (int rep = 0; rep < 2; rep++) begin
      @(negedge clk);
      clear_mon();
      sw_a[2] = 1'b1;
      wait_cnt(0, 2, 20);
      check($sformatf("hold%0d_rise", rep), rise_n[2], 1);
      wait_cnt(2, 2, 30);
      check($sformatf("hold%0d_pulse", rep), hold_n[2], 1);
      check($sformatf("hold%0d_delay", rep), hold_at[2] - rise_at[2], 20);
      repeat (30) @(negedge clk);
      check($sformatf("hold%0d_no_repeat", rep), hold_n[2], 1);
      check($sformatf("hold%0d_single_rise", rep), rise_n[2], 1);
      sw_a[2] = 1'b0;
      wait_cnt(1, 2, 20);
      check($sformatf("hold%0d_fall", rep), fall_n[2], 1);
      check($sformatf("hold%0d_state", rep), st_a[2], 0);
    end

    // Reset while ch1 sits at count 2 (one tick short of acceptance).
    @(negedge clk);
    clear_mon();
    sw_a[1] = 1'b1;
    repeat (10) @(negedge clk);
    rst_a = 1'b1;
    sw_a[1] = 1'b0;
    @(posedge clk); #2;
    check("rst_mid_outputs", {st_a, ri_a, fa_a, ho_a, any_a}, 17'd0);
    @(negedge clk);
    rst_a = 1'b0;
    repeat (20) @(negedge clk);
    check("rst_mid_no_rise", rise_n[1], 0);
    check("rst_mid_no_any", any_n, 0);

    // TICK_DIV=1 instance with INIT_LEVEL=4'b1000.
    @(negedge clk);
    rst_b = 1'b0;
    repeat (3) @(negedge clk);
    clear_mon();
    check("b_init_state", st_b, 4'b1000);
    sw_b = 4'b0001;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #2;
      if (i < 4)
        check($sformatf("b_simul%0d", i), {st_b, ri_b, fa_b, any_b}, {4'b1000, 4'b0000, 4'b0000, 1'b0});
      else if (i == 4)
        check($sformatf("b_simul%0d", i), {st_b, ri_b, fa_b, any_b}, {4'b0001, 4'b0001, 4'b1000, 1'b1});
      else
        check($sformatf("b_simul%0d", i), {st_b, ri_b, fa_b, any_b}, {4'b0001, 4'b0000, 4'b0000, 1'b0});
    end

    // Two clocks high is one short of three; three clocks is just enough.
    @(negedge clk);
    clear_mon();
    sw_b[1] = 1'b1;
    repeat (2) @(negedge clk);
    sw_b[1] = 1'b0;
    repeat (8) @(negedge clk);
    check("b_glitch_state", st_b[1], 0);
    check("b_glitch_no_rise", rise_b_n[1], 0);
    sw_b[1] = 1'b1;
    repeat (3) @(negedge clk);
    sw_b[1] = 1'b0;
    repeat (8) @(negedge clk);
    check("b_min_pulse_rise", rise_b_n[1], 1);

    check("any_matches_edges", any_bad, 0);
    check("no_rise_and_fall_together", both_n, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
